// File: rtl/data_memory_bus_target.sv
// Word-addressed data memory behind a simple request/ready bus, with fixed wait states.
// Optional alignment checking is enabled by defining DMEM_TARGET_ALIGN_CHECK_EN.
`timescale 1ns/1ps

module data_memory_bus_target #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_write_data,
    input  logic [3:0]  bus_byte_enable,
    input  logic        bus_read_enable,
    input  logic        bus_write_enable,
    output logic [31:0] bus_read_data,
    output logic        bus_ready,
    output logic        bus_error
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;

    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic        rd_q, wr_q;

    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        req_rd, req_wr;

    logic [32:0] offset;
    logic        in_range, align_err, acc_err, start, commit;
    logic [IDX_W-1:0] index;

    logic        ready_d, ready_q, error_d, error_q;
    logic [31:0] rdata_d, rdata_q;

    logic [31:0] mem_q [DEPTH_WORDS];

    assign start = (state_q == S_IDLE) && (bus_read_enable || bus_write_enable);

    // With zero wait states the response is decided on the sampling edge itself,
    // so the live bus inputs stand in for the not-yet-latched request.
    always_comb begin
        if (state_q == S_IDLE) begin
            req_addr  = bus_address;
            req_wdata = bus_write_data;
            req_be    = bus_byte_enable;
            req_rd    = bus_read_enable;
            req_wr    = bus_write_enable;
        end else begin
            req_addr  = addr_q;
            req_wdata = wdata_q;
            req_be    = be_q;
            req_rd    = rd_q;
            req_wr    = wr_q;
        end
    end

    // 33-bit arithmetic keeps the upper bound from wrapping past 2^32.
    assign offset   = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    assign in_range = (req_addr >= BASE_ADDR) && (offset < SPAN);
    assign index    = offset[IDX_W+1:2];

`ifdef DMEM_TARGET_ALIGN_CHECK_EN
    assign align_err = (req_be == 4'b0000) || !req_be[req_addr[1:0]];
`else
    assign align_err = 1'b0;
`endif

    assign acc_err = !in_range || (req_rd && req_wr) || align_err;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 4'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (WAIT_STATES > 0) begin
                        state_d    = S_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: response values are computed on the edge that enters RESP.
    always_comb begin
        ready_d = (state_d == S_RESP);
        error_d = ready_d && acc_err;
        rdata_d = '0;
        if (ready_d && req_rd && !acc_err) begin
            rdata_d = mem_q[index];
        end
    end

    assign commit = ready_d && req_wr && !acc_err && !reset;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else if (start) begin
            addr_q  <= bus_address;
            wdata_q <= bus_write_data;
            be_q    <= bus_byte_enable;
            rd_q    <= bus_read_enable;
            wr_q    <= bus_write_enable;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
            error_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= ready_d;
            error_q <= error_d;
            rdata_q <= rdata_d;
        end
    end

    // NOTE: the memory array has no reset; contents survive reset and map onto plain RAM.
    always_ff @(posedge clock) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (req_be[i]) begin
                    mem_q[index][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus_ready     = ready_q;
    assign bus_error     = error_q;
    assign bus_read_data = rdata_q;

endmodule

// File: tb/tb_data_memory_bus_target.sv
// Directed bench for data_memory_bus_target: three instances with 1, 3 and 0 wait states.
`timescale 1ns/1ps

module tb_data_memory_bus_target;

    logic        clk;
    logic        rst;
    logic [31:0] bus_address;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic [2:0]  rd_en, wr_en;
    logic [31:0] rdata_w [3];
    logic [2:0]  ready_w, err_w;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] rd;
    logic        er;
    int          lat;

    data_memory_bus_target #(.WAIT_STATES(1)) u_ws1 (
        .clock(clk), .reset(rst),
        .bus_address(bus_address), .bus_write_data(bus_write_data),
        .bus_byte_enable(bus_byte_enable),
        .bus_read_enable(rd_en[0]), .bus_write_enable(wr_en[0]),
        .bus_read_data(rdata_w[0]), .bus_ready(ready_w[0]), .bus_error(err_w[0])
    );

    data_memory_bus_target #(.WAIT_STATES(3)) u_ws3 (
        .clock(clk), .reset(rst),
        .bus_address(bus_address), .bus_write_data(bus_write_data),
        .bus_byte_enable(bus_byte_enable),
        .bus_read_enable(rd_en[1]), .bus_write_enable(wr_en[1]),
        .bus_read_data(rdata_w[1]), .bus_ready(ready_w[1]), .bus_error(err_w[1])
    );

    data_memory_bus_target #(.WAIT_STATES(0)) u_ws0 (
        .clock(clk), .reset(rst),
        .bus_address(bus_address), .bus_write_data(bus_write_data),
        .bus_byte_enable(bus_byte_enable),
        .bus_read_enable(rd_en[2]), .bus_write_enable(wr_en[2]),
        .bus_read_data(rdata_w[2]), .bus_ready(ready_w[2]), .bus_error(err_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One bus transaction on instance inst; lat is the edge count from sampling to ready (0 = timeout).
    task automatic access(input int inst, input logic rd_i, input logic wr_i,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                          output logic [31:0] rdata, output logic err, output int cycles);
        @(negedge clk);
        bus_address     = addr;
        bus_write_data  = wdata;
        bus_byte_enable = be;
        rd_en[inst]     = rd_i;
        wr_en[inst]     = wr_i;
        cycles = 0;
        rdata  = '0;
        err    = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (ready_w[inst]) begin
                cycles = k;
                rdata  = rdata_w[inst];
                err    = err_w[inst];
                break;
            end
        end
        rd_en[inst] = 1'b0;
        wr_en[inst] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        bus_address     = '0;
        bus_write_data  = '0;
        bus_byte_enable = '0;
        rd_en           = '0;
        wr_en           = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(ready_w), 32'd0);
        check("reset_error", 32'(err_w), 32'd0);
        check("reset_rdata", rdata_w[0], 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Basic write then read, WAIT_STATES=1.
        access(0, 1'b0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        check("wr_latency", 32'(lat), 32'd2);
        check("wr_error", 32'(er), 32'd0);
        check("wr_rdata_zero", rd, 32'h0);
        check("after_resp_ready", 32'(ready_w[0]), 32'd0);
        access(0, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'hF, rd, er, lat);
        check("rd_latency", 32'(lat), 32'd2);
        check("rd_error", 32'(er), 32'd0);
        check("rd_data", rd, 32'hDEAD_BEEF);

        // Single byte-lane merge.
        access(0, 1'b0, 1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, rd, er, lat);
        access(0, 1'b0, 1'b1, 32'h8000_0020, 32'h0000_AA00, 4'b0010, rd, er, lat);
        check("lane_wr_error", 32'(er), 32'd0);
        access(0, 1'b1, 1'b0, 32'h8000_0020, 32'h0, 4'hF, rd, er, lat);
        check("lane_merge", rd, 32'h1122_AA44);

        // Range boundaries.
        access(0, 1'b0, 1'b1, 32'h8000_0000, 32'h0123_4567, 4'hF, rd, er, lat);
        access(0, 1'b0, 1'b1, 32'h8000_0FFC, 32'hA5A5_0FFC, 4'hF, rd, er, lat);
        access(0, 1'b1, 1'b0, 32'h8000_0FFC, 32'h0, 4'hF, rd, er, lat);
        check("last_word", rd, 32'hA5A5_0FFC);
        check("last_word_err", 32'(er), 32'd0);
        access(0, 1'b0, 1'b1, 32'h8000_1000, 32'hBAD0_BAD0, 4'hF, rd, er, lat);
        check("oor_wr_latency", 32'(lat), 32'd2);
        check("oor_wr_error", 32'(er), 32'd1);
        access(0, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'hF, rd, er, lat);
        check("oor_no_wrap", rd, 32'h0123_4567);
        access(0, 1'b1, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'hF, rd, er, lat);
        check("below_base_ready", 32'(lat), 32'd2);
        check("below_base_error", 32'(er), 32'd1);
        check("below_base_data", rd, 32'h0);
        access(0, 1'b1, 1'b0, 32'h8000_1000, 32'h0, 4'hF, rd, er, lat);
        check("above_top_error", 32'(er), 32'd1);
        check("above_top_data", rd, 32'h0);

        // Misaligned address with a partial byte enable.
`ifdef DMEM_TARGET_ALIGN_CHECK_EN
        access(0, 1'b1, 1'b0, 32'h8000_0002, 32'h0, 4'b0001, rd, er, lat);
        check("align_bad_error", 32'(er), 32'd1);
        check("align_bad_data", rd, 32'h0);
        access(0, 1'b1, 1'b0, 32'h8000_0002, 32'h0, 4'b1100, rd, er, lat);
        check("align_ok_error", 32'(er), 32'd0);
        check("align_ok_data", rd, 32'h0123_4567);
`else
        access(0, 1'b1, 1'b0, 32'h8000_0002, 32'h0, 4'b0001, rd, er, lat);
        check("noalign_error", 32'(er), 32'd0);
        check("noalign_data", rd, 32'h0123_4567);
`endif

        // Both enables set, WAIT_STATES=0.
        access(2, 1'b0, 1'b1, 32'h8000_0040, 32'hCAFE_F00D, 4'hF, rd, er, lat);
        check("ws0_wr_latency", 32'(lat), 32'd1);
        access(2, 1'b1, 1'b1, 32'h8000_0040, 32'h1234_5678, 4'hF, rd, er, lat);
        check("both_latency", 32'(lat), 32'd1);
        check("both_error", 32'(er), 32'd1);
        check("both_data", rd, 32'h0);
        access(2, 1'b1, 1'b0, 32'h8000_0040, 32'h0, 4'hF, rd, er, lat);
        check("both_no_write", rd, 32'hCAFE_F00D);

        // Reset while a write sits in WAIT, WAIT_STATES=3.
        access(1, 1'b0, 1'b1, 32'h8000_0030, 32'h55AA_55AA, 4'hF, rd, er, lat);
        check("ws3_wr_latency", 32'(lat), 32'd4);
        @(negedge clk);
        bus_address     = 32'h8000_0030;
        bus_write_data  = 32'hFFFF_FFFF;
        bus_byte_enable = 4'hF;
        wr_en[1]        = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_ready", 32'(ready_w[1]), 32'd0);
        check("abort_error", 32'(err_w[1]), 32'd0);
        wr_en[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        access(1, 1'b1, 1'b0, 32'h8000_0030, 32'h0, 4'hF, rd, er, lat);
        check("abort_rd_latency", 32'(lat), 32'd4);
        check("abort_no_commit", rd, 32'h55AA_55AA);

        // Reset while the response is being presented clears outputs at once.
        @(negedge clk);
        bus_address     = 32'h8000_0010;
        bus_byte_enable = 4'hF;
        rd_en[0]        = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("resp_ready_pre", 32'(ready_w[0]), 32'd1);
        check("resp_data_pre", rdata_w[0], 32'hDEAD_BEEF);
        rst = 1'b1;
        #1;
        check("resp_ready_rst", 32'(ready_w[0]), 32'd0);
        check("resp_data_rst", rdata_w[0], 32'h0);
        rd_en[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        access(0, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'hF, rd, er, lat);
        check("post_rst_latency", 32'(lat), 32'd2);
        check("mem_survives_rst", rd, 32'hDEAD_BEEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_memory_bus_target.md
DATA_MEMORY_BUS_TARGET -- requirements
Module: data_memory_bus_target

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-002 Parameters SHALL be, one per line: name, default, meaning:
- DEPTH_WORDS, 1024, number of 32-bit words in the memory array (power of two).
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- WAIT_STATES, 1, cycles (0..15) spent in WAIT before the response.
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning:
- clock, in, 1, rising-edge clock.
- reset, in, 1, asynchronous active-high reset.
- bus_address, in, 32, byte address from the initiator.
- bus_write_data, in, 32, store data, lane-aligned.
- bus_byte_enable, in, 4, per-byte-lane write/read mask.
- bus_read_enable, in, 1, read request.
- bus_write_enable, in, 1, write request.
- bus_read_data, out, 32, full read word (unmasked); 0 on error or write.
- bus_ready, out, 1, one-cycle response strobe.
- bus_error, out, 1, error flag, valid only while bus_ready=1.

Function
REQ-004 The block SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-005 IDLE: if bus_read_enable or bus_write_enable is 1, the block SHALL latch address, write data, byte enable and op; next state is WAIT if WAIT_STATES>0, else RESP.
REQ-006 WAIT: the wait counter SHALL load WAIT_STATES-1 on entry and decrement each cycle; at 0 the next state is RESP.
REQ-007 RESP SHALL last exactly one cycle, then return to IDLE; no new request is sampled in RESP.
REQ-008 Latency from request sampled in IDLE (cycle 0) to bus_ready=1 SHALL be WAIT_STATES+1 cycles.
REQ-009 bus_ready, bus_error and bus_read_data SHALL be registered; they SHALL be driven only during RESP and SHALL be 0 in all other states.
REQ-010 Request inputs SHALL be ignored outside IDLE; the initiator holds the request until bus_ready and drops it the cycle after.
REQ-011 Word index SHALL be (latched_address - BASE_ADDR) >> 2. An access is in range when BASE_ADDR <= address < BASE_ADDR + 4*DEPTH_WORDS; the compare is unsigned with no wrap.
REQ-012 Read in range: bus_read_data SHALL be mem[index] sampled at RESP entry, with bus_error=0.
REQ-013 Write in range: each byte lane i with latched byte_enable[i]=1 SHALL be updated on the edge that enters RESP; other lanes SHALL be unchanged.
REQ-014 A read in RESP of a word written by the immediately preceding request SHALL return the new data.
REQ-015 An out-of-range access SHALL produce no memory access, bus_error=1 and bus_read_data=0.
REQ-016 A request with both enables set SHALL produce bus_error=1, no write, and bus_read_data=0.

Reset
REQ-017 Reset SHALL force IDLE, wait counter=0, bus_ready=0, bus_error=0, bus_read_data=0, and all latched request registers=0.
REQ-018 Reset in WAIT or RESP SHALL abort the access; a write still in WAIT SHALL never commit. Memory contents SHALL NOT be reset.

Configuration
REQ-019 Macro DMEM_TARGET_ALIGN_CHECK_EN SHALL control alignment checking.
- Defined: a request with byte_enable=4'b0000, or with byte_enable[address[1:0]]=0, SHALL be flagged bus_error=1 and perform no memory access.
- Undefined: no alignment check; address[1:0] is ignored and byte_enable is applied as given.

Verification
REQ-020 WAIT_STATES=1: write 0xDEADBEEF, be=4'hF, to 0x8000_0010 -> bus_ready=1 two cycles later, error=0; then read 0x8000_0010 -> 0xDEADBEEF.
REQ-021 Write 0x0000_AA00, be=4'b0010, over a word holding 0x11223344 -> read returns 0x1122AA44.
REQ-022 Read 0x7FFF_FFFC, then read 0x8000_1000 (DEPTH_WORDS=1024) -> each gives bus_ready=1, bus_error=1, data=0x0.
REQ-023 Assert reset one cycle after a write request sampled, WAIT_STATES=3 -> all outputs 0 immediately, state IDLE; later read shows the old word unchanged.
REQ-024 Read and write enables both 1 -> bus_error=1, no write; WAIT_STATES=0 -> bus_ready on cycle 1.
REQ-025 With DMEM_TARGET_ALIGN_CHECK_EN: read at 0x8000_0002 with be=4'b0001 -> bus_error=1; with be=4'b1100 -> error=0, full word returned.
